// File: rtl/branch_controller.sv
// branch_controller
//   Sequences one control-transfer instruction (conditional branch, JAL,
//   JALR) at a time through the registered branch-resolution unit, then
//   offers the resulting next PC to fetch, writes the link value back, or
//   raises a one-cycle exception. Counts taken redirects accepted by fetch.
//
// Ports
//   clk, reset_n          rising-edge clock, synchronous active-low reset
//   req_*                 request from decode (valid/ready)
//   bu_*                  operands held steady into the branch unit;
//                         bu_result_pc is its registered next-PC
//   redirect_*            next PC offered to fetch (valid/ready)
//   writeback_*           one-cycle link register write pulse
//   exception_*           one-cycle fault pulse (01 illegal, 10 misaligned)
//   taken_count           number of taken redirects accepted by fetch
//   debug_state           current FSM state (IDLE=0 EXECUTE=1 REDIRECT=2 FAULT=3)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Once redirect_valid rises, redirect_pc/redirect_taken stay
// constant until that edge; req_ready never depends on req_valid.
module branch_controller #(
  parameter int XLEN        = 32,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_kind,
  input  logic [XLEN-1:0]        req_pc,
  input  logic [2:0]             req_subfunction_3,
  input  logic [XLEN-1:0]        req_immediate,
  input  logic [XLEN-1:0]        req_rs1_value,
  input  logic [XLEN-1:0]        req_rs2_value,
  input  logic [4:0]             req_rd,
  output logic [XLEN-1:0]        bu_program_counter,
  output logic [2:0]             bu_subfunction_3,
  output logic [XLEN-1:0]        bu_immediate,
  output logic [XLEN-1:0]        bu_rs1_value,
  output logic [XLEN-1:0]        bu_rs2_value,
  input  logic [XLEN-1:0]        bu_result_pc,
  output logic                   redirect_valid,
  input  logic                   redirect_ready,
  output logic [XLEN-1:0]        redirect_pc,
  output logic                   redirect_taken,
  output logic                   writeback_valid,
  output logic [4:0]             writeback_rd,
  output logic [XLEN-1:0]        writeback_value,
  output logic                   exception_valid,
  output logic [1:0]             exception_cause,
  output logic [XLEN-1:0]        exception_pc,
  output logic [COUNT_WIDTH-1:0] taken_count,
  output logic [1:0]             debug_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXECUTE  = 2'd1,
    REDIRECT = 2'd2,
    FAULT    = 2'd3
  } state_t;

  localparam logic [1:0] KIND_BRANCH = 2'b00;
  localparam logic [1:0] KIND_JAL    = 2'b01;
  localparam logic [1:0] KIND_ILLEGAL = 2'b11;

  localparam logic [1:0] CAUSE_ILLEGAL    = 2'b01;
  localparam logic [1:0] CAUSE_MISALIGNED = 2'b10;

  state_t            state, state_next;
  logic [1:0]        kind_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   target_q;   // JAL/JALR target computed during EXECUTE

  logic              accept;
  logic              illegal;
  logic [XLEN-1:0]   target;
  logic [XLEN-1:0]   link_pc;
  logic              misaligned;
  logic              handshake;

  always_comb begin
    accept  = (state == IDLE) && req_valid;
    // funct3 010/011 are unused branch encodings
    illegal = (req_kind == KIND_ILLEGAL) ||
              ((req_kind == KIND_BRANCH) && (req_subfunction_3[2:1] == 2'b01));
    // bu_* stay constant through REDIRECT, so the unit's registered result
    // is stable for the whole redirect, including any fetch stall.
    target     = (kind_q == KIND_BRANCH) ? bu_result_pc : target_q;
    link_pc    = bu_program_counter + XLEN'(4);
    misaligned = (target[1:0] != 2'b00);

    req_ready       = (state == IDLE);
    redirect_valid  = (state == REDIRECT) && !misaligned;
    redirect_pc     = redirect_valid ? target : '0;
    redirect_taken  = redirect_valid && (target != link_pc);
    exception_valid = (state == FAULT);
    handshake       = redirect_valid && redirect_ready;
    debug_state     = state;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept) state_next = illegal ? FAULT : EXECUTE;
      EXECUTE:  state_next = REDIRECT;
      REDIRECT: begin
        if (misaligned)          state_next = FAULT;
        else if (redirect_ready) state_next = IDLE;
      end
      FAULT:    state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state              <= IDLE;
      kind_q             <= '0;
      rd_q               <= '0;
      target_q           <= '0;
      bu_program_counter <= '0;
      bu_subfunction_3   <= '0;
      bu_immediate       <= '0;
      bu_rs1_value       <= '0;
      bu_rs2_value       <= '0;
      writeback_valid    <= 1'b0;
      writeback_rd       <= '0;
      writeback_value    <= '0;
      exception_cause    <= '0;
      exception_pc       <= '0;
      taken_count        <= '0;
    end else begin
      state           <= state_next;
      writeback_valid <= 1'b0;

      if (accept) begin
        kind_q <= req_kind;
        rd_q   <= req_rd;
        if (illegal) begin
          exception_cause <= CAUSE_ILLEGAL;
          exception_pc    <= req_pc;
        end else begin
          bu_program_counter <= req_pc;
          bu_subfunction_3   <= req_subfunction_3;
          bu_immediate       <= req_immediate;
          bu_rs1_value       <= req_rs1_value;
          bu_rs2_value       <= req_rs2_value;
        end
      end

      if ((state == EXECUTE) && (kind_q != KIND_BRANCH)) begin
        if (kind_q == KIND_JAL)
          target_q <= bu_program_counter + bu_immediate;
        else
          target_q <= (bu_rs1_value + bu_immediate) & {{(XLEN-1){1'b1}}, 1'b0};
      end

      if ((state == REDIRECT) && misaligned) begin
        exception_cause <= CAUSE_MISALIGNED;
        exception_pc    <= bu_program_counter;
      end

      if (handshake) begin
        if ((kind_q != KIND_BRANCH) && (rd_q != 5'd0)) begin
          writeback_valid <= 1'b1;
          writeback_rd    <= rd_q;
          writeback_value <= link_pc;
        end
        if (redirect_taken)
          taken_count <= taken_count + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_controller.sv
// Testbench for branch_controller: directed cases followed by random
// requests, each checked against a behavioural model of RV32I control
// transfers. The branch unit itself is modelled as a one-cycle register.
module tb_branch_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [31:0] req_pc;
  logic [2:0]  req_subfunction_3;
  logic [31:0] req_immediate;
  logic [31:0] req_rs1_value;
  logic [31:0] req_rs2_value;
  logic [4:0]  req_rd;
  logic [31:0] bu_program_counter;
  logic [2:0]  bu_subfunction_3;
  logic [31:0] bu_immediate;
  logic [31:0] bu_rs1_value;
  logic [31:0] bu_rs2_value;
  logic [31:0] bu_result_pc;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;
  logic        redirect_taken;
  logic        writeback_valid;
  logic [4:0]  writeback_rd;
  logic [31:0] writeback_value;
  logic        exception_valid;
  logic [1:0]  exception_cause;
  logic [31:0] exception_pc;
  logic [31:0] taken_count;
  logic [1:0]  debug_state;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_count = '0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  branch_controller #(.XLEN(32), .COUNT_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_pc(req_pc), .req_subfunction_3(req_subfunction_3),
    .req_immediate(req_immediate), .req_rs1_value(req_rs1_value),
    .req_rs2_value(req_rs2_value), .req_rd(req_rd),
    .bu_program_counter(bu_program_counter), .bu_subfunction_3(bu_subfunction_3),
    .bu_immediate(bu_immediate), .bu_rs1_value(bu_rs1_value),
    .bu_rs2_value(bu_rs2_value), .bu_result_pc(bu_result_pc),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .redirect_taken(redirect_taken),
    .writeback_valid(writeback_valid), .writeback_rd(writeback_rd),
    .writeback_value(writeback_value), .exception_valid(exception_valid),
    .exception_cause(exception_cause), .exception_pc(exception_pc),
    .taken_count(taken_count), .debug_state(debug_state)
  );

  // ---------------- reference behaviour
  function automatic logic cond_holds(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) <  $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a <  b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Registered branch unit: next-PC appears one cycle after operands.
  always @(posedge clk)
    bu_result_pc <= cond_holds(bu_subfunction_3, bu_rs1_value, bu_rs2_value)
                    ? bu_program_counter + bu_immediate : bu_program_counter + 32'd4;

  // ---------------- scoreboard compare
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // ---------------- driver: one full request, called at a negedge
  task automatic do_req(input logic [1:0] kind, input logic [31:0] pc,
                        input logic [2:0] f3, input logic [31:0] imm,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [4:0] rd, input int stall);
    int          cause;
    logic [31:0] tgt;
    logic        tk;
    logic        wb;
    int          n;
    cause = 0;
    tgt   = '0;
    if (kind == 2'b11 || (kind == 2'b00 && (f3 == 3'b010 || f3 == 3'b011)))
      cause = 1;
    else begin
      if (kind == 2'b00)      tgt = cond_holds(f3, rs1, rs2) ? pc + imm : pc + 32'd4;
      else if (kind == 2'b01) tgt = pc + imm;
      else                    tgt = (rs1 + imm) & 32'hFFFF_FFFE;
      if (tgt[1:0] != 2'b00) cause = 2;
    end
    tk = (tgt != pc + 32'd4);
    wb = (kind != 2'b00) && (rd != 5'd0);
    exp_q.push_back(tgt);

    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", {31'd0, req_ready}, 32'd1);

    req_valid = 1'b1; req_kind = kind; req_pc = pc; req_subfunction_3 = f3;
    req_immediate = imm; req_rs1_value = rs1; req_rs2_value = rs2; req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0;
    req_rs1_value = $urandom;   // operands must already be latched

    if (cause == 1) begin
      chk("ill_exc_valid", {31'd0, exception_valid}, 32'd1);
      chk("ill_exc_cause", {30'd0, exception_cause}, 32'd1);
      chk("ill_exc_pc", exception_pc, pc);
      chk("ill_redirect", {31'd0, redirect_valid}, 32'd0);
      @(negedge clk);
      chk("ill_exc_drop", {31'd0, exception_valid}, 32'd0);
      chk("ill_ready", {31'd0, req_ready}, 32'd1);
      void'(exp_q.pop_front());
      return;
    end

    chk("exec_ready", {31'd0, req_ready}, 32'd0);
    chk("exec_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("exec_bu_pc", bu_program_counter, pc);
    chk("exec_bu_rs1", bu_rs1_value, rs1);
    @(negedge clk);

    if (cause == 2) begin
      chk("mis_redirect", {31'd0, redirect_valid}, 32'd0);
      @(negedge clk);
      chk("mis_exc_valid", {31'd0, exception_valid}, 32'd1);
      chk("mis_exc_cause", {30'd0, exception_cause}, 32'd2);
      chk("mis_exc_pc", exception_pc, pc);
      chk("mis_redirect2", {31'd0, redirect_valid}, 32'd0);
      @(negedge clk);
      chk("mis_exc_drop", {31'd0, exception_valid}, 32'd0);
      chk("mis_wb", {31'd0, writeback_valid}, 32'd0);
      chk("mis_count", taken_count, exp_count);
      void'(exp_q.pop_front());
      return;
    end

    chk("rd_valid", {31'd0, redirect_valid}, 32'd1);
    chk("rd_pc", redirect_pc, exp_q[0]);
    chk("rd_taken", {31'd0, redirect_taken}, {31'd0, tk});
    chk("rd_exc", {31'd0, exception_valid}, 32'd0);
    for (int s = 0; s < stall; s++) begin
      redirect_ready = 1'b0;
      @(negedge clk);
      chk("stall_valid", {31'd0, redirect_valid}, 32'd1);
      chk("stall_pc", redirect_pc, exp_q[0]);
      chk("stall_ready", {31'd0, req_ready}, 32'd0);
      chk("stall_wb", {31'd0, writeback_valid}, 32'd0);
    end
    redirect_ready = 1'b1;
    @(negedge clk);
    redirect_ready = 1'b0;
    if (tk) exp_count = exp_count + 32'd1;
    void'(exp_q.pop_front());
    chk("done_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("done_ready", {31'd0, req_ready}, 32'd1);
    chk("done_wb_valid", {31'd0, writeback_valid}, {31'd0, wb});
    if (wb) begin
      chk("done_wb_rd", {27'd0, writeback_rd}, {27'd0, rd});
      chk("done_wb_value", writeback_value, pc + 32'd4);
    end
    chk("done_count", taken_count, exp_count);
    @(negedge clk);
    chk("wb_pulse_end", {31'd0, writeback_valid}, 32'd0);
  endtask

  // ---------------- directed + random sequence
  initial begin
    logic [31:0] r;
    logic [1:0]  k;
    logic [31:0] a;
    reset_n = 1'b0; req_valid = 1'b0; req_kind = '0; req_pc = '0;
    req_subfunction_3 = '0; req_immediate = '0; req_rs1_value = '0;
    req_rs2_value = '0; req_rd = '0; redirect_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_state", {30'd0, debug_state}, 32'd0);
    chk("rst_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("rst_exc", {31'd0, exception_valid}, 32'd0);
    chk("rst_wb", {31'd0, writeback_valid}, 32'd0);
    chk("rst_count", taken_count, 32'd0);
    chk("rst_bu_pc", bu_program_counter, 32'd0);

    do_req(2'b00, 32'h100, 3'b000, 32'h20, 32'd5, 32'd5, 5'd0, 0);           // BEQ taken
    do_req(2'b00, 32'h200, 3'b110, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd1, 5'd0, 0); // BLTU not taken
    do_req(2'b00, 32'h200, 3'b100, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd1, 5'd0, 0); // BLT taken
    do_req(2'b10, 32'h40, 3'b000, 32'd2, 32'h1003, 32'd0, 5'd1, 5);          // JALR, stalled
    do_req(2'b01, 32'h80, 3'b000, 32'h6, 32'd0, 32'd0, 5'd1, 0);             // JAL misaligned
    do_req(2'b00, 32'h90, 3'b010, 32'h10, 32'd0, 32'd0, 5'd0, 0);            // illegal funct3
    do_req(2'b11, 32'hA0, 3'b000, 32'h10, 32'd0, 32'd0, 5'd4, 0);            // illegal kind
    do_req(2'b01, 32'h300, 3'b000, 32'h10, 32'd0, 32'd0, 5'd0, 1);           // JAL rd=0
    do_req(2'b01, 32'hFFFF_FFFC, 3'b000, 32'd8, 32'd0, 32'd0, 5'd3, 0);      // JAL wrap
    do_req(2'b00, 32'h400, 3'b001, 32'd4, 32'd1, 32'd2, 5'd0, 0);            // imm=4 not taken
    do_req(2'b01, 32'h500, 3'b000, 32'd4, 32'd0, 32'd0, 5'd7, 0);            // JAL to pc+4

    // Reset while a redirect is stalled: nothing completes, everything clears.
    req_valid = 1'b1; req_kind = 2'b10; req_pc = 32'h600; req_subfunction_3 = 3'b000;
    req_immediate = 32'd0; req_rs1_value = 32'h2000; req_rs2_value = 32'd0; req_rd = 5'd2;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_pre_valid", {31'd0, redirect_valid}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    exp_count = '0;
    chk("abort_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("abort_redirect_pc", redirect_pc, 32'd0);
    chk("abort_wb", {31'd0, writeback_valid}, 32'd0);
    chk("abort_exc", {31'd0, exception_valid}, 32'd0);
    chk("abort_count", taken_count, 32'd0);
    chk("abort_bu_pc", bu_program_counter, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    chk("abort_wb_later", {31'd0, writeback_valid}, 32'd0);
    do_req(2'b01, 32'h700, 3'b000, 32'h40, 32'd0, 32'd0, 5'd9, 0);

    for (int i = 0; i < 60; i++) begin
      r = $urandom;
      k = 2'($urandom_range(0, 3));
      a = $urandom;
      do_req(k, $urandom & 32'hFFFF_FFFC, 3'($urandom_range(0, 7)),
             {{20{r[11]}}, r[11:1], 1'b0}, a,
             ($urandom_range(0, 2) == 0) ? a : $urandom,
             5'($urandom_range(0, 31)), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
